bids_n_auction: RTL and testbench

//  N-bidder sealed-round auction engine; generalises the fixed 3-bidder (X/Y/Z) controller to NUMBIDDERS.

---
 rtl/bids_n_auction_pkg.sv | 39 +++
 rtl/bids_n_auction_if.sv | 32 +++
 rtl/bids_n_auction_bidder_slot.sv | 72 +++++++
 rtl/bids_n_auction.sv | 174 +++++++++++++++++
 tb/tb_bids_n_auction.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bids_n_auction_pkg.sv
// Shared types for the N-bidder auction engine: opcodes, controller and bidder error codes.
package bids_n_defs;

    localparam int DATAWIDTH  = 32;
    localparam int BIDAMTBITS = DATAWIDTH / 2;

    typedef enum logic [3:0] {
        NO_OP        = 4'd0,
        UNLOCK       = 4'd1,
        LOCK         = 4'd2,
        SELECT       = 4'd3,
        LOADV        = 4'd4,
        SETMASK      = 4'd5,
        SETTIMER     = 4'd6,
        SETBIDCHARGE = 4'd7
    } opcodes_t;

    typedef enum logic [2:0] {
        NOERROR            = 3'd0,
        ALREADYUNLOCKED    = 3'd1,
        CSTARTWHENUNLOCKED = 3'd2,
        INVALID_OP         = 3'd3,
        BADKEY             = 3'd4,
        DUPLICATEBIDS      = 3'd5
    } outerrors_t;

    typedef enum logic [2:0] {
        BID_NOERROR       = 3'd0,
        ROUNDINACTIVE     = 3'd1,
        INSUFFICIENTFUNDS = 3'd2,
        INVALIDREQUEST    = 3'd3
    } biderrors_t;

    // Code 8 is reserved and silently ignored; anything above it is rejected.
    function automatic logic undefined_op(input logic [3:0] op);
        return op > 4'd8;
    endfunction

endpackage

// File: rtl/bids_n_auction_if.sv
// Control port plus flattened bidder channels of the auction engine.
interface bids_n_if #(
    parameter int DATAWIDTH  = 32,
    parameter int NUMBIDDERS = 4
);
    localparam int BIDAMTBITS = DATAWIDTH / 2;

    logic [DATAWIDTH-1:0]             C_data;
    logic [3:0]                       C_op;
    logic                             C_start;
    logic [NUMBIDDERS-1:0]            bid;
    logic [NUMBIDDERS-1:0]            retract;
    logic [NUMBIDDERS*BIDAMTBITS-1:0] bidAmt;
    logic [NUMBIDDERS-1:0]            ack;
    logic [NUMBIDDERS*3-1:0]          bid_err;
    logic [NUMBIDDERS*DATAWIDTH-1:0]  balance;
    logic [NUMBIDDERS-1:0]            win;
    logic                             ready;
    logic [2:0]                       err;
    logic                             roundOver;
    logic [DATAWIDTH-1:0]             maxBid;

    modport master (
        output C_data, C_op, C_start, bid, retract, bidAmt,
        input  ack, bid_err, balance, win, ready, err, roundOver, maxBid
    );

    modport slave (
        input  C_data, C_op, C_start, bid, retract, bidAmt,
        output ack, bid_err, balance, win, ready, err, roundOver, maxBid
    );
endinterface

// File: rtl/bids_n_auction_bidder_slot.sv
// One bidder's escrow: balance, standing bid, and per-request accept/reject response.
module bids_n_bidder_slot #(
    parameter int DATAWIDTH  = 32,
    parameter int BIDAMTBITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active,
    input  logic                  mask_bit,
    input  logic                  outbid_ok,
    input  logic                  bid,
    input  logic                  retract,
    input  logic [BIDAMTBITS-1:0] bid_amt,
    input  logic [DATAWIDTH-1:0]  charge,
    input  logic                  load_en,
    input  logic [DATAWIDTH-1:0]  load_val,
    input  logic                  settle,
    input  logic                  refund,
    output logic [DATAWIDTH-1:0]  balance,
    output logic [BIDAMTBITS-1:0] lastbid,
    output logic                  ack,
    output logic [2:0]            bid_err
);
    import bids_n_defs::*;

    logic [DATAWIDTH:0] avail;
    logic [DATAWIDTH:0] need;
    logic [DATAWIDTH:0] remain;

    // Funds available to a new bid include the standing bid it would replace.
    assign avail  = {1'b0, balance} + {{(DATAWIDTH + 1 - BIDAMTBITS){1'b0}}, lastbid};
    assign need   = {{(DATAWIDTH + 1 - BIDAMTBITS){1'b0}}, bid_amt} + {1'b0, charge};
    assign remain = avail - need;

    always_ff @(posedge clk) begin
        if (reset) begin
            balance <= '0;
            lastbid <= '0;
            ack     <= 1'b0;
            bid_err <= BID_NOERROR;
        end else begin
            ack     <= 1'b0;
            bid_err <= BID_NOERROR;
            if (load_en) begin
                balance <= load_val;
            end else if (settle) begin
                if (refund) balance <= avail[DATAWIDTH-1:0];
                lastbid <= '0;
            end
            // Settle and load never coincide with an active round, so no update clashes.
            if (retract) begin
                if (active) begin
                    ack     <= 1'b1;
                    balance <= avail[DATAWIDTH-1:0];
                    lastbid <= '0;
                end else begin
                    bid_err <= ROUNDINACTIVE;
                end
            end else if (bid) begin
                if (!active)                 bid_err <= ROUNDINACTIVE;
                else if (!mask_bit)          bid_err <= INVALIDREQUEST;
                else if (avail < need)       bid_err <= INSUFFICIENTFUNDS;
                else if (!outbid_ok)         bid_err <= INVALIDREQUEST;
                else begin
                    ack     <= 1'b1;
                    balance <= remain[DATAWIDTH-1:0];
                    lastbid <= bid_amt;
                end
            end
        end
    end
endmodule

// File: rtl/bids_n_auction.sv
// N-bidder sealed-round auction controller: lock/key FSM, round timer, winner/tie resolution.
// Optional BIDS_OUTBID_CHECK_EN: a bid must strictly exceed the current round maximum.
module bids_n_auction #(
    parameter int DATAWIDTH  = bids_n_defs::DATAWIDTH,
    parameter int NUMBIDDERS = 4
) (
    input logic    clk,
    input logic    reset,
    bids_n_if.slave bus
);
    import bids_n_defs::*;

    localparam int BIDAMTBITS = DATAWIDTH / 2;
    localparam int IDXW       = $clog2(NUMBIDDERS);

    localparam logic [1:0] S_UNLOCKED = 2'd0;
    localparam logic [1:0] S_LOCKED   = 2'd1;
    localparam logic [1:0] S_ROUND    = 2'd2;
    localparam logic [1:0] S_RESULT   = 2'd3;

    logic [1:0]            state;
    logic [DATAWIDTH-1:0]  key;
    logic [IDXW-1:0]       sel;
    logic [NUMBIDDERS-1:0] mask;
    logic [DATAWIDTH-1:0]  timer;
    logic [DATAWIDTH-1:0]  counter;
    logic [DATAWIDTH-1:0]  charge;

    logic [BIDAMTBITS-1:0] lastbid [NUMBIDDERS];
    logic [BIDAMTBITS-1:0] cur_max;
    logic [NUMBIDDERS-1:0] hits;
    logic [NUMBIDDERS-1:0] win_vec;
    logic [NUMBIDDERS-1:0] refund;
    logic [NUMBIDDERS-1:0] load_en;
    logic [NUMBIDDERS-1:0] outbid_ok;
    logic                  dup;
    logic                  close;
    logic                  round_active;

    always_comb begin
        cur_max = '0;
        for (int i = 0; i < NUMBIDDERS; i++)
            if (lastbid[i] > cur_max) cur_max = lastbid[i];
        hits = '0;
        for (int i = 0; i < NUMBIDDERS; i++)
            hits[i] = (cur_max != '0) && (lastbid[i] == cur_max);
    end

    // More than one bit set among the max holders means a tie.
    assign dup     = (hits & (hits - NUMBIDDERS'(1))) != '0;
    assign win_vec = dup ? '0 : hits;
    assign refund  = ~win_vec;

    assign close        = (state == S_ROUND) &&
                          (!bus.C_start || (timer != '0 && counter == DATAWIDTH'(1)));
    assign round_active = (state == S_ROUND) && !close;

    always_comb begin
        load_en = '0;
        for (int i = 0; i < NUMBIDDERS; i++)
            load_en[i] = (state == S_UNLOCKED) && (bus.C_op == LOADV) && (sel == IDXW'(i));
    end

    always_comb begin
`ifdef BIDS_OUTBID_CHECK_EN
        for (int i = 0; i < NUMBIDDERS; i++)
            outbid_ok[i] = bus.bidAmt[i*BIDAMTBITS +: BIDAMTBITS] > cur_max;
`else
        outbid_ok = '1;
`endif
    end

    for (genvar i = 0; i < NUMBIDDERS; i++) begin : g_slot
        bids_n_bidder_slot #(
            .DATAWIDTH (DATAWIDTH),
            .BIDAMTBITS(BIDAMTBITS)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .active   (round_active),
            .mask_bit (mask[i]),
            .outbid_ok(outbid_ok[i]),
            .bid      (bus.bid[i]),
            .retract  (bus.retract[i]),
            .bid_amt  (bus.bidAmt[i*BIDAMTBITS +: BIDAMTBITS]),
            .charge   (charge),
            .load_en  (load_en[i]),
            .load_val (bus.C_data),
            .settle   (close),
            .refund   (refund[i]),
            .balance  (bus.balance[i*DATAWIDTH +: DATAWIDTH]),
            .lastbid  (lastbid[i]),
            .ack      (bus.ack[i]),
            .bid_err  (bus.bid_err[i*3 +: 3])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_UNLOCKED;
            key           <= '0;
            sel           <= '0;
            mask          <= '1;
            timer         <= '0;
            counter       <= '0;
            charge        <= '0;
            bus.err       <= NOERROR;
            bus.ready     <= 1'b1;
            bus.roundOver <= 1'b0;
            bus.win       <= '0;
            bus.maxBid    <= '0;
        end else begin
            bus.err       <= NOERROR;
            bus.roundOver <= 1'b0;
            bus.win       <= '0;
            case (state)
                S_UNLOCKED: begin
                    if (bus.C_start) bus.err <= CSTARTWHENUNLOCKED;
                    case (bus.C_op)
                        UNLOCK: bus.err <= ALREADYUNLOCKED;
                        LOCK: begin
                            key   <= bus.C_data;
                            state <= S_LOCKED;
                        end
                        SELECT: begin
                            if (bus.C_data < DATAWIDTH'(NUMBIDDERS)) sel <= bus.C_data[IDXW-1:0];
                            else                                      bus.err <= INVALID_OP;
                        end
                        SETMASK:      mask   <= bus.C_data[NUMBIDDERS-1:0];
                        SETTIMER:     timer  <= bus.C_data;
                        SETBIDCHARGE: charge <= bus.C_data;
                        default:      if (undefined_op(bus.C_op)) bus.err <= INVALID_OP;
                    endcase
                end
                S_LOCKED: begin
                    if (bus.C_start) begin
                        state      <= S_ROUND;
                        counter    <= timer;
                        bus.maxBid <= '0;
                        bus.ready  <= 1'b0;
                        if (bus.C_op != NO_OP) bus.err <= INVALID_OP;
                    end else begin
                        case (bus.C_op)
                            NO_OP: ;
                            UNLOCK: begin
                                if (bus.C_data == key) state <= S_UNLOCKED;
                                else                   bus.err <= BADKEY;
                            end
                            default: if (bus.C_op != 4'd8) bus.err <= INVALID_OP;
                        endcase
                    end
                end
                S_ROUND: begin
                    if (bus.C_op != NO_OP) bus.err <= INVALID_OP;
                    // Resolution happens on the closing edge; the slots settle on the same edge.
                    if (close) begin
                        state         <= S_RESULT;
                        bus.roundOver <= 1'b1;
                        bus.win       <= win_vec;
                        bus.maxBid    <= dup ? '0 : DATAWIDTH'(cur_max);
                        if (dup) bus.err <= DUPLICATEBIDS;
                    end else if (timer != '0) begin
                        counter <= counter - DATAWIDTH'(1);
                    end
                end
                default: begin
                    if (bus.C_op != NO_OP) bus.err <= INVALID_OP;
                    state     <= S_LOCKED;
                    bus.ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bids_n_auction.sv
// Directed and randomized checks of bids_n_auction against an escrow-level reference model.
module tb_bids_n_auction;
    import bids_n_defs::*;

    localparam int DW = 32;
    localparam int NB = 4;
    localparam int BA = DW / 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    bids_n_if #(.DATAWIDTH(DW), .NUMBIDDERS(NB)) bus();

    bids_n_auction #(.DATAWIDTH(DW), .NUMBIDDERS(NB)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    longint        mbal [NB];
    longint        mlb  [NB];
    longint        mcharge;
    logic [NB-1:0] mmask;
    logic [NB-1:0] eack;
    logic [2:0]    eerr_b [NB];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] code, input logic [DW-1:0] d);
        bus.C_op   = code;
        bus.C_data = d;
        step();
        bus.C_op   = NO_OP;
        bus.C_data = '0;
    endtask

    task automatic load(input int idx, input int unsigned val);
        op(SELECT, DW'(idx));
        op(LOADV, DW'(val));
        mbal[idx] = val;
    endtask

    function automatic logic [NB*BA-1:0] amts(input int a0, input int a1, input int a2, input int a3);
        logic [NB*BA-1:0] v;
        v = {BA'(a3), BA'(a2), BA'(a1), BA'(a0)};
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            mbal[i]   = 0;
            mlb[i]    = 0;
            eerr_b[i] = BID_NOERROR;
        end
        mmask   = '1;
        mcharge = 0;
        eack    = '0;
    endtask

    task automatic check_slots(input string tag);
        chk({tag, "_ack"}, 64'(bus.ack), 64'(eack));
        for (int i = 0; i < NB; i++) begin
            chk($sformatf("%s_biderr%0d", tag, i), 64'(bus.bid_err[i*3 +: 3]), 64'(eerr_b[i]));
            chk($sformatf("%s_bal%0d", tag, i), 64'(bus.balance[i*DW +: DW]), mbal[i]);
        end
    endtask

    // One in-round request cycle: escrow rules applied bidder by bidder.
    task automatic req(input string tag, input logic [NB-1:0] b, input logic [NB-1:0] r,
                       input logic [NB*BA-1:0] a);
        longint rmax;
        longint am;
        rmax = 0;
        for (int i = 0; i < NB; i++) if (mlb[i] > rmax) rmax = mlb[i];
        eack = '0;
        for (int i = 0; i < NB; i++) begin
            eerr_b[i] = BID_NOERROR;
            am = longint'(a[i*BA +: BA]);
            if (r[i]) begin
                eack[i] = 1'b1;
                mbal[i] = mbal[i] + mlb[i];
                mlb[i]  = 0;
            end else if (b[i]) begin
                if (!mmask[i])                         eerr_b[i] = INVALIDREQUEST;
                else if (mbal[i] + mlb[i] < am + mcharge) eerr_b[i] = INSUFFICIENTFUNDS;
`ifdef BIDS_OUTBID_CHECK_EN
                else if (am <= rmax)                   eerr_b[i] = INVALIDREQUEST;
`endif
                else begin
                    eack[i] = 1'b1;
                    mbal[i] = mbal[i] + mlb[i] - am - mcharge;
                    mlb[i]  = am;
                end
            end
        end
        bus.bid     = b;
        bus.retract = r;
        bus.bidAmt  = a;
        step();
        bus.bid     = '0;
        bus.retract = '0;
        check_slots(tag);
    endtask

    task automatic settle_check(input string tag);
        longint        mx;
        longint        emb;
        int            cnt;
        int            w;
        logic [NB-1:0] ew;
        logic [2:0]    ee;
        mx = 0; emb = 0; cnt = 0; w = 0; ew = '0; ee = NOERROR;
        for (int i = 0; i < NB; i++) if (mlb[i] > mx) mx = mlb[i];
        for (int i = 0; i < NB; i++)
            if (mx != 0 && mlb[i] == mx) begin
                cnt++;
                w = i;
            end
        if (cnt > 1) ee = DUPLICATEBIDS;
        else if (cnt == 1) begin
            ew[w] = 1'b1;
            emb   = mx;
        end
        for (int i = 0; i < NB; i++) begin
            if (!(cnt == 1 && i == w)) mbal[i] = mbal[i] + mlb[i];
            mlb[i]    = 0;
            eerr_b[i] = BID_NOERROR;
        end
        eack = '0;
        bus.C_start = 1'b0;
        step();
        chk({tag, "_roundOver"}, 64'(bus.roundOver), 64'(1));
        chk({tag, "_win"}, 64'(bus.win), 64'(ew));
        chk({tag, "_maxBid"}, 64'(bus.maxBid), emb);
        chk({tag, "_err"}, 64'(bus.err), 64'(ee));
        chk({tag, "_ready_result"}, 64'(bus.ready), 64'(0));
        check_slots(tag);
        step();
        chk({tag, "_roundOver_off"}, 64'(bus.roundOver), 64'(0));
        chk({tag, "_win_off"}, 64'(bus.win), 64'(0));
        chk({tag, "_ready_back"}, 64'(bus.ready), 64'(1));
        chk({tag, "_maxBid_held"}, 64'(bus.maxBid), emb);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(bus.ready), 64'(1));
        chk({tag, "_err"}, 64'(bus.err), 64'(NOERROR));
        chk({tag, "_roundOver"}, 64'(bus.roundOver), 64'(0));
        chk({tag, "_win"}, 64'(bus.win), 64'(0));
        chk({tag, "_maxBid"}, 64'(bus.maxBid), 64'(0));
        check_slots(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        logic [NB-1:0] rb;
        logic [NB-1:0] rr;
        bus.C_op    = NO_OP;
        bus.C_data  = '0;
        bus.C_start = 1'b0;
        bus.bid     = '0;
        bus.retract = '0;
        bus.bidAmt  = '0;
        model_reset();

        // Reset values
        reset = 1'b1;
        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b0;

        // Single bidder wins an untimed round
        load(2, 100);
        op(LOCK, 'h55);
        chk("lock_err", 64'(bus.err), 64'(NOERROR));
        chk("lock_ready", 64'(bus.ready), 64'(1));
        bus.C_start = 1'b1;
        step();
        chk("round_ready", 64'(bus.ready), 64'(0));
        req("t1_bid", 4'b0100, 4'b0000, amts(0, 0, 40, 0));
        settle_check("t1");

        // Key handling
        op(UNLOCK, 'h54);
        chk("badkey_err", 64'(bus.err), 64'(BADKEY));
        chk("badkey_ready", 64'(bus.ready), 64'(1));
        op(UNLOCK, 'h55);
        chk("unlock_err", 64'(bus.err), 64'(NOERROR));
        op(UNLOCK, 'h0);
        chk("already_unlocked", 64'(bus.err), 64'(ALREADYUNLOCKED));
        op(SELECT, 7);
        chk("select_range", 64'(bus.err), 64'(INVALID_OP));

        // Timed round closes by itself
        op(SETTIMER, 5);
        op(LOCK, 'h11);
        op(SETTIMER, 1);
        chk("config_in_locked", 64'(bus.err), 64'(INVALID_OP));
        bus.C_start = 1'b1;
        step();
        cnt = 0;
        for (int k = 0; k < 12 && !bus.roundOver; k++) begin
            step();
            cnt++;
        end
        bus.C_start = 1'b0;
        chk("timer_roundOver", 64'(bus.roundOver), 64'(1));
        chk("timer_len", 64'(cnt), 64'(5));
        chk("timer_nobid_win", 64'(bus.win), 64'(0));
        chk("timer_nobid_max", 64'(bus.maxBid), 64'(0));
        step();
        chk("timer_ready_back", 64'(bus.ready), 64'(1));
        bus.bid    = 4'b0001;
        bus.bidAmt = amts(1, 0, 0, 0);
        step();
        bus.bid = '0;
        chk("inactive_ack", 64'(bus.ack), 64'(0));
        chk("inactive_err", 64'(bus.bid_err[2:0]), 64'(ROUNDINACTIVE));

        // Bid charge, insufficient funds, retraction
        op(UNLOCK, 'h11);
        op(SETTIMER, 0);
        op(SETBIDCHARGE, 3);
        mcharge = 3;
        load(0, 10);
        op(LOCK, 1);
        bus.C_start = 1'b1;
        step();
        op(SETMASK, 0);
        chk("op_in_round", 64'(bus.err), 64'(INVALID_OP));
        req("t4_short", 4'b0001, 4'b0000, amts(8, 0, 0, 0));
        req("t4_exact", 4'b0001, 4'b0000, amts(7, 0, 0, 0));
        req("t4_retract", 4'b0000, 4'b0001, amts(0, 0, 0, 0));
        settle_check("t4");

        // Tie and masked bidder
        op(UNLOCK, 1);
        op(SETBIDCHARGE, 0);
        mcharge = 0;
        op(SETMASK, 'h7);
        mmask = 4'h7;
        load(0, 50);
        load(1, 50);
        op(LOCK, 2);
        bus.C_start = 1'b1;
        step();
        req("t5_tie", 4'b0011, 4'b0000, amts(20, 20, 0, 0));
        req("t5_masked", 4'b1000, 4'b0000, amts(0, 0, 0, 1));
        settle_check("t5");

        // Randomized rounds
        for (int r = 0; r < 12; r++) begin
            op(UNLOCK, 2);
            chk("rnd_unlock", 64'(bus.err), 64'(NOERROR));
            mmask = NB'($urandom_range(0, 15));
            op(SETMASK, DW'(mmask));
            mcharge = $urandom_range(0, 3);
            op(SETBIDCHARGE, DW'(mcharge));
            for (int i = 0; i < NB; i++) load(i, $urandom_range(0, 200));
            op(LOCK, 2);
            bus.C_start = 1'b1;
            step();
            chk("rnd_maxBid_cleared", 64'(bus.maxBid), 64'(0));
            for (int c = 0; c < 8; c++) begin
                rb = NB'($urandom);
                rr = NB'($urandom & $urandom & $urandom);
                req("rnd", rb, rr, amts($urandom_range(0, 120), $urandom_range(0, 120),
                                        $urandom_range(0, 120), $urandom_range(0, 120)));
            end
            settle_check("rnd");
        end

`ifdef BIDS_OUTBID_CHECK_EN
        op(UNLOCK, 2);
        op(SETMASK, 'hF);
        mmask = 4'hF;
        op(SETBIDCHARGE, 0);
        mcharge = 0;
        load(0, 100);
        load(1, 100);
        op(LOCK, 2);
        bus.C_start = 1'b1;
        step();
        req("t6_first", 4'b0001, 4'b0000, amts(30, 0, 0, 0));
        req("t6_equal", 4'b0010, 4'b0000, amts(0, 30, 0, 0));
        settle_check("t6");
`endif

        // Reset in the middle of a round
        op(UNLOCK, 2);
        op(SETMASK, 'hF);
        mmask = 4'hF;
        op(SETBIDCHARGE, 0);
        mcharge = 0;
        load(3, 77);
        op(LOCK, 2);
        bus.C_start = 1'b1;
        step();
        req("t6_pre", 4'b1000, 4'b0000, amts(0, 0, 0, 10));
        bus.C_start = 1'b0;
        reset = 1'b1;
        step();
        model_reset();
        check_reset_outputs("midreset");
        reset = 1'b0;
        bus.C_start = 1'b1;
        step();
        bus.C_start = 1'b0;
        chk("cstart_unlocked", 64'(bus.err), 64'(CSTARTWHENUNLOCKED));
        chk("cstart_ready", 64'(bus.ready), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
